operand_entry: RTL and testbench
================================

# operand_entry

Input front end for the two-operand summator on the DE2-115 board. Debounces the two active-low push buttons and captures two 16-bit operands from the slide switches. Presents the operand pair to the downstream adder over a valid/ready handshake. This is the input end of the switches/keys → summator → HEX display path.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms at 50 MHz). Consecutive stable cycles required before the debounced level changes. Must be ≥ 2.
- `WIDTH`, default 16. Operand width; equals the switch bus width.

Ports:
- `clk`, input, 1. 50 MHz board clock; all logic on its rising edge.
- `rst_n`, input, 1. Asynchronous, active-low reset.
- `key0`, input, 1. Raw button, 0 when pressed. Captures the next operand.
- `key1`, input, 1. Raw button, 0 when pressed. Clears the entry.
- `sw`, input, WIDTH. Raw slide switches; operand value.
- `op_a`, output, WIDTH. First captured operand.
- `op_b`, output, WIDTH. Second captured operand.
- `out_valid`, output, 1. Operand pair is complete and stable.
- `out_ready`, input, 1. Consumer accepts the pair.
- `state_led`, output, 2. Current FSM state, for LEDG.

## Operation

Button conditioning, per key:
- Two-flop synchronizer.
- Debounced level resets to 1 (released).
- A counter runs while the synced value differs from the debounced level and clears whenever they match.
- When the counter reaches `DEBOUNCE_CYCLES - 1`, the debounced level takes the synced value and the counter clears.
- A press pulse is asserted for exactly one cycle when the debounced level goes 1→0. Release generates nothing.

`sw` is sampled directly on the press-pulse cycle. Switches are quasi-static, so no synchronizer is used.

FSM states (encoded `EMPTY`=0, `HAVE_A`=1, `FULL`=2 on `state_led`):
- `EMPTY`: on press0, `op_a` ← `sw`, go to `HAVE_A`.
- `HAVE_A`: on press0, `op_b` ← `sw`, go to `FULL`.
- `FULL`: `out_valid`=1.
  - On `out_valid && out_ready`, go to `EMPTY`. `op_a` and `op_b` keep their values.
  - press0 is ignored.
- press1 in any state: go to `EMPTY`, `op_a`=`op_b`=0.
  - press1 has priority over press0 in the same cycle.
  - In `FULL` with press1 and a handshake in the same cycle, the transfer counts as completed, then registers clear.
- `op_a`/`op_b` change only on the events above. They are stable for the whole time `out_valid` is high.

Reset values: `op_a`=0, `op_b`=0, `out_valid`=0, `state_led`=0, debounced levels=1, counters=0, press pulses=0.

## Timing

- `out_valid` is registered and equals (state == `FULL`). No combinational path from `out_ready` to any output.
- Latency from a clean press edge on the pin to the press pulse: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 cycles. With `DEBOUNCE_CYCLES`=4, that is 7 cycles.
- Bounce shorter than `DEBOUNCE_CYCLES` cycles: no pulse.
- A held button: exactly one pulse.
- The FSM state and captured operand update on the clock edge ending the press-pulse cycle.
- `out_valid` rises on the cycle after the second press pulse.
- `out_valid` falls on the cycle after the handshake.
- Back-to-back: a press0 arriving in the same cycle as the handshake is ignored. A new capture needs a later press.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first press after release is still debounced in full.

## Structure

- Shared package `summ_pkg`:
  - FSM state enum (`EMPTY`, `HAVE_A`, `FULL`).
  - `WIDTH` default constant.
  - Board debounce constant.
- Sub-module `key_debounce`, instantiated twice. Ports: `clk`, `rst_n`, `key_n`, `level`, `press`. Parameter: `DEBOUNCE_CYCLES`.
- Top-level `operand_entry` holds the FSM and operand registers. Expected size 150–250 lines total.

## Test plan

Benches run with `DEBOUNCE_CYCLES`=4.

1. Reset: assert `rst_n`=0 mid-run → all outputs 0 with no clock edge. After release, `state_led`=0.
2. Capture: `sw`=0x1234, press key0 (held 10 cycles), release; `sw`=0xABCD, press key0, release; `out_ready`=0 → `op_a`=0x1234, `op_b`=0xABCD, `out_valid`=1, `state_led`=2. All hold for 20 cycles.
3. Bounce rejection: key0 toggles low/high every 2 cycles for 20 cycles, then held high → no pulse, state stays `EMPTY`. Held low for 10 cycles → exactly one capture.
4. Handshake: in `FULL`, raise `out_ready` for one cycle → `out_valid`=0 the next cycle, `state_led`=0, operands unchanged. A third key0 press while in `FULL` beforehand → no change.
5. Clear priority: in `HAVE_A` with `op_a`=0x00FF, press key0 and key1 with identical waveforms → state `EMPTY`, `op_a`=`op_b`=0.
6. Clear plus handshake: in `FULL` with `out_ready`=1 and a press1 pulse in the same cycle → exactly one cycle of `out_valid`&`out_ready` is observed, then `EMPTY` with operands 0.

Source files
------------

// File: rtl/summ_pkg.sv
// Shared types and constants for the switches/keys -> summator -> HEX display path.
package summ_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    FULL   = 2'd2
  } entry_state_t;

  localparam int SUMM_WIDTH = 16;

  // 20 ms of stable level at the 50 MHz board clock.
  localparam int BOARD_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/key_debounce.sv
// Conditions one active-low push button: synchronizer, debounced level and a
// one-cycle press pulse on each debounced 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = summ_pkg::BOARD_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_p2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= 1'b1;
      sync_p1  <= 1'b1;
      level    <= 1'b1;
      level_p2 <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      // synchronizer stages
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;

      // stability counter: any agreement restarts the count
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // edge detect on the debounced level; releases produce nothing
      level_p2 <= level;
      press    <= level_p2 & ~level;
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Captures two operands from the slide switches on debounced key0 presses and
// offers the pair downstream over valid/ready; key1 clears the entry.
module operand_entry
  import summ_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
  parameter int WIDTH           = SUMM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key0,
  input  logic             key1,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       state_led
);

  logic press0;
  logic press1;
  logic key0_level_unused;
  logic key1_level_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key0),
    .level (key0_level_unused),
    .press (press0)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key1),
    .level (key1_level_unused),
    .press (press1)
  );

  entry_state_t state;
  entry_state_t state_nxt;
  logic         load_a;
  logic         load_b;
  logic         clear;

  always_comb begin
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    clear     = 1'b0;
    case (state)
      EMPTY: begin
        if (press0) begin
          state_nxt = HAVE_A;
          load_a    = 1'b1;
        end
      end
      HAVE_A: begin
        if (press0) begin
          state_nxt = FULL;
          load_b    = 1'b1;
        end
      end
      FULL: begin
        if (out_valid && out_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // clear wins over capture; a coincident handshake still completes
    if (press1) begin
      state_nxt = EMPTY;
      load_a    = 1'b0;
      load_b    = 1'b0;
      clear     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == FULL);
      if (clear) begin
        op_a <= '0;
        op_b <= '0;
      end else if (load_a) begin
        op_a <= sw;
      end else if (load_b) begin
        op_b <= sw;
      end
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window.
module tb_operand_entry;

  localparam int DC = 4;
  localparam int W  = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key0;
  logic         key1;
  logic [W-1:0] sw;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   state_led;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  operand_entry #(.DEBOUNCE_CYCLES(DC), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key0      (key0),
    .key1      (key1),
    .sw        (sw),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_led (state_led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press key0 at a falling edge, return edges until state_led shows want_state.
  task automatic press0_measure(input logic [1:0] want_state, output int lat);
    key0 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (state_led == want_state && lat == 0) lat = i;
    end
    if (lat == 0) lat = 99;
    key0 = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic press0(input int hold);
    key0 = 1'b0;
    repeat (hold) @(negedge clk);
    key0 = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  int lat;
  int hs_before;

  initial begin
    rst_n = 1'b0; key0 = 1'b1; key1 = 1'b1; sw = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", 32'(state_led), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_op_a", 32'(op_a), 32'd0);
    check("reset_op_b", 32'(op_b), 32'd0);

    // capture two operands
    sw = 16'h1234;
    press0_measure(2'd1, lat);
    check("latency_a", 32'(lat), 32'd8);
    check("cap_a_state", 32'(state_led), 32'd1);
    check("cap_a_op_a", 32'(op_a), 32'h1234);
    check("cap_a_valid", 32'(out_valid), 32'd0);
    sw = 16'hABCD;
    press0(10);
    check("cap_b_op_a", 32'(op_a), 32'h1234);
    check("cap_b_op_b", 32'(op_b), 32'hABCD);
    check("cap_b_valid", 32'(out_valid), 32'd1);
    check("cap_b_state", 32'(state_led), 32'd2);
    sw = 16'h5A5A;
    repeat (20) @(negedge clk);
    check("hold_op_a", 32'(op_a), 32'h1234);
    check("hold_op_b", 32'(op_b), 32'hABCD);
    check("hold_valid", 32'(out_valid), 32'd1);

    // asynchronous reset away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_op_a", 32'(op_a), 32'd0);
    check("async_rst_op_b", 32'(op_b), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_state", 32'(state_led), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(state_led), 32'd0);

    // bounce shorter than the window must not register
    sw = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      key0 = 1'b0;
      repeat (2) @(negedge clk);
      key0 = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce_state", 32'(state_led), 32'd0);
    check("bounce_op_a", 32'(op_a), 32'd0);
    press0_measure(2'd1, lat);
    check("latency_after_rst", 32'(lat), 32'd8);
    check("one_capture_state", 32'(state_led), 32'd1);
    check("one_capture_op_a", 32'(op_a), 32'h5555);

    // fill, then a third press while FULL is ignored
    sw = 16'h7777;
    press0(10);
    check("full2_state", 32'(state_led), 32'd2);
    sw = 16'h9999;
    press0(10);
    check("ign_press_state", 32'(state_led), 32'd2);
    check("ign_press_op_a", 32'(op_a), 32'h5555);
    check("ign_press_op_b", 32'(op_b), 32'h7777);

    // single-cycle handshake
    out_ready = 1'b1;
    check("hs_valid_before", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_valid_after", 32'(out_valid), 32'd0);
    check("hs_state_after", 32'(state_led), 32'd0);
    check("hs_op_a_kept", 32'(op_a), 32'h5555);
    check("hs_op_b_kept", 32'(op_b), 32'h7777);

    // clear has priority over a simultaneous capture
    sw = 16'h00FF;
    press0(10);
    check("pre_clr_state", 32'(state_led), 32'd1);
    check("pre_clr_op_a", 32'(op_a), 32'h00FF);
    sw = 16'h0F0F;
    key0 = 1'b0; key1 = 1'b0;
    repeat (10) @(negedge clk);
    key0 = 1'b1; key1 = 1'b1;
    repeat (12) @(negedge clk);
    check("clr_prio_state", 32'(state_led), 32'd0);
    check("clr_prio_op_a", 32'(op_a), 32'd0);
    check("clr_prio_op_b", 32'(op_b), 32'd0);

    // clear coinciding with a handshake
    sw = 16'h0101;
    press0(10);
    sw = 16'h0202;
    press0(10);
    check("pre_clrhs_state", 32'(state_led), 32'd2);
    hs_before = hs_cnt;
    key1 = 1'b0;
    repeat (7) @(negedge clk);
    out_ready = 1'b1;
    check("clrhs_valid_at_hs", 32'(out_valid), 32'd1);
    check("clrhs_op_b_at_hs", 32'(op_b), 32'h0202);
    @(negedge clk);
    out_ready = 1'b0;
    check("clrhs_valid_after", 32'(out_valid), 32'd0);
    check("clrhs_state_after", 32'(state_led), 32'd0);
    check("clrhs_op_a", 32'(op_a), 32'd0);
    check("clrhs_op_b", 32'(op_b), 32'd0);
    key1 = 1'b1;
    repeat (12) @(negedge clk);
    check("clrhs_hs_count", 32'(hs_cnt - hs_before), 32'd1);
    check("clrhs_final_state", 32'(state_led), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
